div_seq_ctrl: RTL

//  Multi-cycle sequencer for the DIV/DIVU execution path. It captures the operands,

---
 rtl/mdu_pkg.sv | 15 +
 rtl/div_seq_ctrl_if.sv | 29 ++
 rtl/div_seq_ctrl_step.sv | 29 ++
 rtl/div_seq_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit sequencers.
package mdu_pkg;

    localparam int                     MDU_WIDTH  = 32;
    localparam int                     DIV_ITERS  = MDU_WIDTH;
    localparam logic [MDU_WIDTH-1:0]   DIVZERO_LO = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Issue-side request/response bundle of the divide sequencer.
interface div_seq_ctrl_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             HALT;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output HALT, start, is_signed, dividend, divisor,
        input  busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  HALT, start, is_signed, dividend, divisor,
        output busy, stall, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One restoring-division step: shift {R,Q} left, subtract D when it fits.
module div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH+1:0] r_shift;
    logic [WIDTH+1:0] d_ext;

    always_comb begin
        r_shift = {r_in, q_in[WIDTH-1]};
        d_ext   = {2'b00, d};
        if (r_shift >= d_ext) begin
            r_out = (WIDTH+1)'(r_shift - d_ext);
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = (WIDTH+1)'(r_shift);
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer: latches operands, runs WIDTH restoring steps, fixes signs, writes HI/LO.
module div_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic           clk,
    input  logic           reset_all,
    div_seq_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;
    logic             a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .d     (d_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (!bus.HALT) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        // A zero divisor skips the iterations; the raw dividend rides in Q to FIX.
                        cnt_d   = '0;
                        r_d     = '0;
                        d_d     = b_neg ? -bus.divisor : bus.divisor;
                        q_d     = (bus.divisor == '0) ? bus.dividend
                                : (a_neg ? -bus.dividend : bus.dividend);
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = (bus.divisor == '0) ? S_FIX : S_ITER;
                    end
                end
                S_ITER: begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (d_q == '0) begin
                        lo_d  = {WIDTH{1'b1}};
                        hi_d  = q_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = q_neg_q ? -q_q : q_q;
                        hi_d = r_neg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Combinational so the issue stage freezes in the very cycle the request is accepted.
    assign bus.stall       = busy_q | (bus.start & (state_q == S_IDLE) & ~bus.HALT);
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
